rc4_keystream_xor: RTL
======================

Name: rc4_keystream_xor

Overview:
- Downstream consumer of the RC4 nibble datapath.
- Fetches the 16 finished keystream nibbles from the datapath's output buffer by driving its rd_1/add_to_read port pair.
- Buffers the nibbles in a small FIFO and XORs them one-for-one with a plaintext nibble stream, producing a ciphertext stream over valid/ready handshakes.
- Decryption is the same operation.

Parameters:
- W, 4, nibble width (fixed to match the datapath).
- BLOCK_LEN, 16, keystream nibbles per datapath block; ks_addr runs 0..BLOCK_LEN-1.
- FIFO_DEPTH, 4, keystream FIFO entries (power of two, 2..8).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- flush  in  1  synchronous clear of FIFO, FSM, output register; priority over all other inputs.
- ks_ready  in  1  level from the datapath: keystream block fully written and readable.
- ks_rd  out  1  read strobe to the datapath output buffer (drives rd_1).
- ks_addr  out  4  read address (drives add_to_read).
- ks_data  in  W  keystream nibble, valid exactly 1 cycle after ks_rd with ks_addr.
- ks_block_done  out  1  1-cycle pulse: all BLOCK_LEN nibbles captured; datapath may start the next block.
- pt_valid  in  1  plaintext nibble valid.
- pt_ready  out  1  block accepts plaintext this cycle.
- pt_data  in  W  plaintext nibble.
- ct_valid  out  1  ciphertext register holds data.
- ct_ready  in  1  downstream accepts ciphertext.
- ct_data  out  W  ciphertext nibble.
- ks_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset / flush values:
  - All outputs 0: ks_rd, ks_addr, ks_block_done, pt_ready, ct_valid, ct_data, ks_level.
  - FSM = IDLE; in-flight flag cleared.
- Reset or flush asserted mid-fetch:
  - Abandons the block; no ks_block_done pulse.
  - The next fetch restarts at addr 0 once the datapath presents ks_ready again.
- Fetch FSM:
  - IDLE: when ks_ready=1, go to FETCH with addr=0.
  - FETCH: assert ks_rd with ks_addr=addr only when ks_level + inflight < FIFO_DEPTH, otherwise stall with ks_rd=0. Each issue increments addr. After issuing addr BLOCK_LEN-1, go to DRAIN.
  - DRAIN: wait for the last in-flight nibble to be captured, then pulse ks_block_done and go to WAIT_LOW.
  - WAIT_LOW: remain until ks_ready=0 (prevents refetching a stale block), then go to IDLE.
  - ks_ready dropping during FETCH/DRAIN is ignored; the block is completed.
- Capture: ks_data is pushed into the FIFO on the cycle after each ks_rd. At most one read is in flight, so there are no back-to-back reads and fetch throughput is 1 nibble per 2 cycles.
- FIFO:
  - Overflow is impossible by construction (credit check includes the in-flight read).
  - A push into an empty FIFO is not visible to the XOR until the next cycle.
  - Simultaneous push and pop: occupancy unchanged.
- XOR path:
  - pt_ready = (ks_level != 0) && (!ct_valid || ct_ready).
  - On pt_valid && pt_ready: pop the FIFO head k; ct_data <= pt_data ^ k; ct_valid <= 1.
  - Latency: 1 cycle from accept to ct_valid.
  - If ct_valid && ct_ready with no new accept, ct_valid <= 0. ct_data holds its value while ct_valid && !ct_ready.
  - Plaintext is never accepted without a keystream nibble; empty FIFO means pt_ready=0.
- Keystream order: nibble at addr n XORs with the n-th plaintext accepted after that block's first nibble. Block boundaries are invisible on the pt/ct side.

Optional Feature:
- Macro RC4_XOR_COUNT_EN.
- When defined:
  - Adds output port ct_count [15:0], counting ct handshakes (ct_valid && ct_ready).
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by reset and flush.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, ks_ready=1, datapath buffer = 0x0..0xF, ct_ready=1, plaintext 0xA x16 → ct stream 0xA,0xB,0x8,0x9,...,0x5. ks_block_done pulses once, after addr 15 is captured. ks_rd is never high on consecutive cycles.
- Backpressure: ct_ready=0 for 10 cycles after the first ct → ct_data is stable, pt_ready=0. ks_level saturates at 4 with no ks_rd issued while full. Release ct_ready → remaining ciphertext is correct, with no nibble lost or duplicated.
- Starvation: pt_valid=1 before ks_ready → pt_ready stays 0. ks_ready=1 at cycle 5 → first ct_valid no earlier than cycle 8, and its value = pt ^ S[0].
- Block handoff: hold ks_ready=1 after ks_block_done → no refetch. Drop ks_ready for 1 cycle, reload the buffer with 0xF..0x0, raise ks_ready → fetch restarts at addr 0 and uses the new data.
- Mid-operation reset/flush at addr 7 with ks_level=3 → next cycle ks_level=0, ct_valid=0, ks_rd=0, no ks_block_done. The next block starts at addr 0.
- RC4_XOR_COUNT_EN defined: 20 ct handshakes → ct_count=20. flush → 0. Preload 0xFFFF + 1 handshake → 0x0000.

Source files
------------

// File: rtl/rc4_keystream_xor.sv
// Fetches RC4 keystream nibbles from the datapath output buffer, queues them and XORs them with plaintext.
// Optional macro RC4_XOR_COUNT_EN adds a 16-bit ciphertext handshake counter on port ct_count.
module rc4_keystream_xor #(
  parameter int W          = 4,
  parameter int BLOCK_LEN  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         ks_ready,
  output logic         ks_rd,
  output logic [3:0]   ks_addr,
  input  logic [W-1:0] ks_data,
  output logic         ks_block_done,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [W-1:0] pt_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [W-1:0] ct_data,
  output logic [3:0]   ks_level
`ifdef RC4_XOR_COUNT_EN
  ,
  output logic [15:0]  ct_count
`endif
);

  localparam int         PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C     = 4'(FIFO_DEPTH);
  localparam logic [3:0] LAST_ADDR_C = 4'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [3:0]     addr_r, addr_s;
  logic           ks_rd_r, ks_rd_s;
  logic [3:0]     ks_addr_r, ks_addr_s;
  logic           done_r, done_s;
  logic           cap_r;
  logic [W-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [3:0]     level_r;
  logic           ct_valid_r;
  logic [W-1:0]   ct_data_r;
  logic           credit_s, push_s, pop_s, pt_ready_s;

  // The pending capture counts against the credit so the FIFO can never overflow.
  assign credit_s   = (level_r + {3'b000, cap_r}) < DEPTH_C;
  assign push_s     = cap_r;
  assign pt_ready_s = (level_r != 4'd0) && (!ct_valid_r || ct_ready);
  assign pop_s      = pt_valid && pt_ready_s;

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fetch FSM next-state and read-issue decode
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    ks_rd_s   = 1'b0;
    ks_addr_s = ks_addr_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ks_ready) begin
          state_s = ST_FETCH;
          addr_s  = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Skipping the cycle after a read keeps at most one read in flight.
        if (!ks_rd_r && credit_s) begin
          ks_rd_s   = 1'b1;
          ks_addr_s = addr_r;
          addr_s    = addr_r + 4'd1;
          if (addr_r == LAST_ADDR_C) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          ks_rd_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!ks_rd_r && cap_r) begin
          done_s  = 1'b1;
          state_s = ST_WAIT_LOW;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_WAIT_LOW: begin
        if (!ks_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_LOW;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Fetch-side registered outputs, address counter and capture tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r    <= 4'd0;
      ks_rd_r   <= 1'b0;
      ks_addr_r <= 4'd0;
      done_r    <= 1'b0;
      cap_r     <= 1'b0;
    end else if (flush) begin
      addr_r    <= 4'd0;
      ks_rd_r   <= 1'b0;
      ks_addr_r <= 4'd0;
      done_r    <= 1'b0;
      cap_r     <= 1'b0;
    end else begin
      addr_r    <= addr_s;
      ks_rd_r   <= ks_rd_s;
      ks_addr_r <= ks_addr_s;
      done_r    <= done_s;
      cap_r     <= ks_rd_r;
    end
  end

  // Keystream FIFO storage
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      fifo_mem_r[wr_ptr_r] <= ks_data;
    end
  end

  // Keystream FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 4'd0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= 4'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 4'd1;
        2'b01:   level_r <= level_r - 4'd1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Ciphertext output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_valid_r <= 1'b0;
      ct_data_r  <= '0;
    end else if (flush) begin
      ct_valid_r <= 1'b0;
      ct_data_r  <= '0;
    end else if (pop_s) begin
      ct_valid_r <= 1'b1;
      ct_data_r  <= pt_data ^ fifo_mem_r[rd_ptr_r];
    end else if (ct_valid_r && ct_ready) begin
      ct_valid_r <= 1'b0;
    end
  end

`ifdef RC4_XOR_COUNT_EN
  logic [15:0] ct_count_r;

  // Ciphertext handshake counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_count_r <= 16'd0;
    end else if (flush) begin
      ct_count_r <= 16'd0;
    end else if (ct_valid_r && ct_ready) begin
      ct_count_r <= ct_count_r + 16'd1;
    end
  end

  assign ct_count = ct_count_r;
`endif

  assign ks_rd         = ks_rd_r;
  assign ks_addr       = ks_addr_r;
  assign ks_block_done = done_r;
  assign pt_ready      = pt_ready_s;
  assign ct_valid      = ct_valid_r;
  assign ct_data       = ct_data_r;
  assign ks_level      = level_r;

endmodule
